// File: rtl/wb_pkg.sv
// Shared widths, slot record and round-robin pointer arithmetic for the writeback arbiter.
// Holds no logic; imported by wb_rr_arbiter and wb_arbiter.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 5;

  typedef struct packed {
    logic                 valid;
    logic [WB_DATA_W-1:0] data;
    logic [WB_ADDR_W-1:0] addr;
  } wb_slot_t;

  // Wraps at n, so non-power-of-two channel counts rotate correctly.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr, with wrap.
// Zero latency, no state; the pointer lives in the parent.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_CH = 2,
  localparam int PTR_W = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PTR_W-1:0]  rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [PTR_W-1:0]  grant_idx,
  output logic              any_grant
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = PTR_W'((int'(rr_ptr) + i) % NUM_CH);
      if (!any_grant && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = idx;
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Merges NUM_CH one-entry writeback slots onto one registered RF write port (1 cycle slot->rf_we);
// a full, ungranted slot deasserts in_ready. WB_ARB_FWD_EN adds a combinational forwarding lookup.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = WB_DATA_W,
  parameter int ADDR_W    = WB_ADDR_W,
  parameter bit DROP_ZERO = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH*ADDR_W-1:0] in_addr,
  output logic                     rf_we,
  output logic [DATA_W-1:0]        data_in,
  output logic [ADDR_W-1:0]        write_address,
`ifdef WB_ARB_FWD_EN
  output logic                     busy,
  input  logic [ADDR_W-1:0]        fwd_addr,
  output logic                     fwd_hit,
  output logic [DATA_W-1:0]        fwd_data
`else
  output logic                     busy
`endif
);

  localparam int PTR_W = $clog2(NUM_CH);

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
  } slot_t;

  slot_t             slot_q [NUM_CH];
  slot_t             slot_d [NUM_CH];
  logic [NUM_CH-1:0] slot_v;
  logic [NUM_CH-1:0] grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              any_grant;
  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              rf_we_q, rf_we_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic [ADDR_W-1:0] write_address_q, write_address_d;

  always_comb begin
    slot_v = '0;
    for (int i = 0; i < NUM_CH; i++) slot_v[i] = slot_q[i].valid;
  end

  wb_rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req       (slot_v),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // A granted slot drains this edge, so it can refill in the same cycle.
  assign in_ready = ~slot_v | grant;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      slot_d[i] = slot_q[i];
      if (grant[i]) slot_d[i].valid = 1'b0;
      if (in_valid[i] && in_ready[i]) begin
        slot_d[i].data = in_data[i*DATA_W +: DATA_W];
        slot_d[i].addr = in_addr[i*ADDR_W +: ADDR_W];
        if (!(DROP_ZERO && (in_addr[i*ADDR_W +: ADDR_W] == '0))) slot_d[i].valid = 1'b1;
      end
    end
  end

  always_comb begin
    rf_we_d         = any_grant;
    data_in_d       = data_in_q;
    write_address_d = write_address_q;
    rr_ptr_d        = rr_ptr_q;
    if (any_grant) begin
      data_in_d       = slot_q[grant_idx].data;
      write_address_d = slot_q[grant_idx].addr;
      rr_ptr_d        = PTR_W'(rr_next(32'(grant_idx), NUM_CH));
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) slot_q[i] <= '0;
      rr_ptr_q        <= '0;
      rf_we_q         <= 1'b0;
      data_in_q       <= '0;
      write_address_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) slot_q[i] <= slot_d[i];
      rr_ptr_q        <= rr_ptr_d;
      rf_we_q         <= rf_we_d;
      data_in_q       <= data_in_d;
      write_address_q <= write_address_d;
    end
  end

  assign rf_we         = rf_we_q;
  assign data_in       = data_in_q;
  assign write_address = write_address_q;
  assign busy          = (|slot_v) | rf_we_q;

`ifdef WB_ARB_FWD_EN
  // Pending slots are younger than the output stage; descending scan lets the lowest index win.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_addr != '0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (slot_q[i].valid && (slot_q[i].addr == fwd_addr)) begin
          fwd_hit  = 1'b1;
          fwd_data = slot_q[i].data;
        end
      end
      if (!fwd_hit && rf_we_q && (write_address_q == fwd_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_in_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: three instances (2ch drop-zero, 2ch keep-zero, 3ch drop-zero) against a
// slot-level reference model, with directed steps followed by random producer traffic.
module tb_wb_arbiter;
  import wb_pkg::*;

  localparam int ND = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [2:0]  iv   [ND];
  logic [95:0] idat [ND];
  logic [14:0] iadr [ND];

  logic [1:0]  rdy_a, rdy_b;
  logic [2:0]  rdy_c;
  logic        we_a, we_b, we_c, bsy_a, bsy_b, bsy_c;
  logic [31:0] dat_a, dat_b, dat_c;
  logic [4:0]  adr_a, adr_b, adr_c;
`ifdef WB_ARB_FWD_EN
  logic [4:0]  fwd_addr;
  logic        fwd_hit_a, fwd_hit_b, fwd_hit_c;
  logic [31:0] fwd_data_a, fwd_data_b, fwd_data_c;
`endif

  wb_arbiter #(.NUM_CH(2), .DATA_W(32), .ADDR_W(5), .DROP_ZERO(1'b1)) dut_a (
    .clock(clock), .reset(reset), .in_valid(iv[0][1:0]), .in_ready(rdy_a),
    .in_data(idat[0][63:0]), .in_addr(iadr[0][9:0]), .rf_we(we_a), .data_in(dat_a),
    .write_address(adr_a), .busy(bsy_a)
`ifdef WB_ARB_FWD_EN
    , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit_a), .fwd_data(fwd_data_a)
`endif
  );

  wb_arbiter #(.NUM_CH(2), .DATA_W(32), .ADDR_W(5), .DROP_ZERO(1'b0)) dut_b (
    .clock(clock), .reset(reset), .in_valid(iv[1][1:0]), .in_ready(rdy_b),
    .in_data(idat[1][63:0]), .in_addr(iadr[1][9:0]), .rf_we(we_b), .data_in(dat_b),
    .write_address(adr_b), .busy(bsy_b)
`ifdef WB_ARB_FWD_EN
    , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit_b), .fwd_data(fwd_data_b)
`endif
  );

  wb_arbiter #(.NUM_CH(3), .DATA_W(32), .ADDR_W(5), .DROP_ZERO(1'b1)) dut_c (
    .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(rdy_c),
    .in_data(idat[2]), .in_addr(iadr[2]), .rf_we(we_c), .data_in(dat_c),
    .write_address(adr_c), .busy(bsy_c)
`ifdef WB_ARB_FWD_EN
    , .fwd_addr(fwd_addr), .fwd_hit(fwd_hit_c), .fwd_data(fwd_data_c)
`endif
  );

  function automatic int nch(input int d);
    return (d == 2) ? 3 : 2;
  endfunction
  function automatic bit dz(input int d);
    return d != 1;
  endfunction
  function automatic logic [2:0] rdy_of(input int d);
    return (d == 0) ? {1'b0, rdy_a} : (d == 1) ? {1'b0, rdy_b} : rdy_c;
  endfunction
  function automatic logic we_of(input int d);
    return (d == 0) ? we_a : (d == 1) ? we_b : we_c;
  endfunction
  function automatic logic bsy_of(input int d);
    return (d == 0) ? bsy_a : (d == 1) ? bsy_b : bsy_c;
  endfunction
  function automatic logic [31:0] dat_of(input int d);
    return (d == 0) ? dat_a : (d == 1) ? dat_b : dat_c;
  endfunction
  function automatic logic [4:0] adr_of(input int d);
    return (d == 0) ? adr_a : (d == 1) ? adr_b : adr_c;
  endfunction

  // Reference model: one pending record per channel, pointer as an integer.
  wb_slot_t    ms   [ND][3];
  int          ptr  [ND];
  int          g    [ND];
  logic        ewe  [ND];
  logic [31:0] edat [ND];
  logic [4:0]  eadr [ND];
  logic [2:0]  erdy [ND];
  bit          acc  [ND][3];

  int total = 0;
  int bad   = 0;
  int seq   = 1;
  int outst [3];
  int waits [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_pre();
    for (int d = 0; d < ND; d++) begin
      g[d] = -1;
      for (int k = 0; k < nch(d); k++) begin
        int c;
        c = (ptr[d] + k) % nch(d);
        if (g[d] < 0 && ms[d][c].valid) g[d] = c;
      end
      erdy[d] = '0;
      for (int c = 0; c < 3; c++) begin
        acc[d][c] = 1'b0;
        if (c < nch(d)) begin
          erdy[d][c] = !ms[d][c].valid || (g[d] == c);
          acc[d][c]  = iv[d][c] && erdy[d][c];
        end
      end
    end
  endtask

  task automatic model_post(input bit in_reset);
    for (int d = 0; d < ND; d++) begin
      if (in_reset) begin
        for (int c = 0; c < 3; c++) ms[d][c] = '0;
        ptr[d] = 0; ewe[d] = 1'b0; edat[d] = '0; eadr[d] = '0;
      end else begin
        ewe[d] = 1'b0;
        if (g[d] >= 0) begin
          ewe[d]  = 1'b1;
          edat[d] = ms[d][g[d]].data;
          eadr[d] = ms[d][g[d]].addr;
          ms[d][g[d]].valid = 1'b0;
          ptr[d] = (g[d] + 1) % nch(d);
        end
        for (int c = 0; c < nch(d); c++) begin
          if (acc[d][c] && !(dz(d) && iadr[d][c*5 +: 5] == 5'd0))
            ms[d][c] = '{valid: 1'b1, data: idat[d][c*32 +: 32], addr: iadr[d][c*5 +: 5]};
        end
      end
    end
  endtask

  // One clock: check in_ready before the edge, outputs 1ns after it.
  task automatic step();
    bit         rst_edge;
    logic [2:0] hs;
    logic       eb;
    int         oc;
    #1;
    model_pre();
    for (int d = 0; d < ND; d++)
      chk($sformatf("in_ready_d%0d", d), 32'(rdy_of(d)), 32'(erdy[d]));
    hs       = iv[2] & rdy_c;
    rst_edge = !reset;
    @(posedge clock);
    #1;
    model_post(rst_edge);
    for (int d = 0; d < ND; d++) begin
      eb = ewe[d];
      for (int c = 0; c < 3; c++) eb = eb | ms[d][c].valid;
      chk($sformatf("rf_we_d%0d", d), 32'(we_of(d)), 32'(ewe[d]));
      chk($sformatf("data_in_d%0d", d), dat_of(d), edat[d]);
      chk($sformatf("waddr_d%0d", d), 32'(adr_of(d)), 32'(eadr[d]));
      chk($sformatf("busy_d%0d", d), 32'(bsy_of(d)), 32'(eb));
    end
    if (rst_edge) begin
      for (int c = 0; c < 3; c++) begin outst[c] = 0; waits[c] = 0; end
    end else begin
      if (we_c === 1'b1) begin
        oc = int'(dat_c[23:16]);
        if (oc < 3) begin
          total++;
          assert (outst[oc] > 0) else begin
            bad++;
            $error("FAIL dup_write ch=%0d observed_outstanding=%0d expected>0", oc, outst[oc]);
          end
          if (outst[oc] > 0) outst[oc]--;
          waits[oc] = 0;
          for (int c = 0; c < 3; c++) begin
            if (c != oc && outst[c] > 0) begin
              waits[c]++;
              total++;
              assert (waits[c] <= 2) else begin
                bad++;
                $error("FAIL wait_bound ch=%0d observed=%0d expected<=2", c, waits[c]);
              end
            end
          end
        end
      end
      for (int c = 0; c < 3; c++)
        if (hs[c] && iadr[2][c*5 +: 5] != 5'd0) outst[c]++;
    end
  endtask

  // mode 0: stop once accepted, 1: random, 2: always valid with nonzero addresses.
  task automatic gen(input int d, input int mode);
    for (int c = 0; c < nch(d); c++) begin
      if (!iv[d][c] || acc[d][c]) begin
        iv[d][c] = (mode == 2) || (mode == 1 && $urandom_range(3, 0) != 0);
        idat[d][c*32 +: 32] = {8'(d), 8'(c), 16'(seq)};
        seq++;
        if (mode == 1 && $urandom_range(5, 0) == 0) iadr[d][c*5 +: 5] = 5'd0;
        else iadr[d][c*5 +: 5] = 5'($urandom_range(31, 1));
      end
    end
  endtask

  initial begin
    int prev;
    for (int d = 0; d < ND; d++) begin iv[d] = '0; idat[d] = '0; iadr[d] = '0; end
    for (int c = 0; c < 3; c++) begin outst[c] = 0; waits[c] = 0; end
`ifdef WB_ARB_FWD_EN
    fwd_addr = '0;
`endif
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    model_post(1'b1);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst_we_d%0d", d), 32'(we_of(d)), 32'd0);
      chk($sformatf("rst_data_d%0d", d), dat_of(d), 32'd0);
      chk($sformatf("rst_addr_d%0d", d), 32'(adr_of(d)), 32'd0);
      chk($sformatf("rst_busy_d%0d", d), 32'(bsy_of(d)), 32'd0);
      chk($sformatf("rst_ready_d%0d", d), 32'(rdy_of(d)), 32'((1 << nch(d)) - 1));
    end
    reset = 1'b1;

    // Single write on channel 0.
    iv[0] = 3'b001; idat[0][31:0] = 32'hDEADBEEF; iadr[0][4:0] = 5'd5;
    step();
    iv[0] = '0;
    step();
    chk("single_we", 32'(we_a), 32'd1);
    chk("single_addr", 32'(adr_a), 32'd5);
    chk("single_data", dat_a, 32'hDEADBEEF);
    step();
    chk("single_we_off", 32'(we_a), 32'd0);
    chk("single_data_hold", dat_a, 32'hDEADBEEF);

    // Contention: both channels always valid, addresses 1 and 2.
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (k == 0 || acc[0][c]) begin idat[0][c*32 +: 32] = 32'(seq); seq++; end
        iadr[0][c*5 +: 5] = 5'(c + 1);
      end
      iv[0] = 3'b011;
      step();
      if (we_a === 1'b1) begin
        if (prev != 0) chk("contention_alternate", 32'(adr_a), 32'(prev ^ 3));
        prev = int'(adr_a);
      end
    end
    iv[0] = '0;
    repeat (3) step();

    // Zero-address write: dropped on dut_a, written on dut_b.
    iv[0] = 3'b010; idat[0][63:32] = 32'd7; iadr[0][9:5] = 5'd0;
    iv[1] = 3'b010; idat[1][63:32] = 32'd7; iadr[1][9:5] = 5'd0;
    #1;
    chk("zero_ready", 32'(rdy_a[1]), 32'd1);
    step();
    iv[0] = '0; iv[1] = '0;
    step();
    chk("zero_drop_we", 32'(we_a), 32'd0);
    chk("zero_keep_we", 32'(we_b), 32'd1);
    chk("zero_keep_addr", 32'(adr_b), 32'd0);
    chk("zero_keep_data", dat_b, 32'd7);
    step();
    chk("zero_drop_we2", 32'(we_a), 32'd0);

`ifdef WB_ARB_FWD_EN
    iv[0] = 3'b010; idat[0][63:32] = 32'h44; iadr[0][9:5] = 5'd9;
    step();
    idat[0][63:32] = 32'h55;
    step();
    iv[0] = '0;
    fwd_addr = 5'd9;
    #1;
    chk("fwd_hit", 32'(fwd_hit_a), 32'd1);
    chk("fwd_data", fwd_data_a, 32'h55);
    fwd_addr = 5'd0;
    #1;
    chk("fwd_zero_hit", 32'(fwd_hit_a), 32'd0);
    chk("fwd_zero_data", fwd_data_a, 32'd0);
    repeat (2) step();
`endif

    // Reset with both slots full.
    iv[0] = 3'b011; idat[0][63:0] = {32'hA2, 32'hA1}; iadr[0][9:0] = {5'd4, 5'd3};
    step();
    iv[0] = '0;
    reset = 1'b0;
    step();
    chk("midrst_we", 32'(we_a), 32'd0);
    chk("midrst_data", dat_a, 32'd0);
    chk("midrst_addr", 32'(adr_a), 32'd0);
    chk("midrst_busy", 32'(bsy_a), 32'd0);
    reset = 1'b1;
    step();
    chk("midrst_no_stale", 32'(we_a), 32'd0);
    step();
    chk("midrst_no_stale2", 32'(we_a), 32'd0);

    // Three channels saturated: strict rotation 0,1,2,0,...
    prev = 0;
    for (int k = 0; k < 40; k++) begin
      gen(2, 2);
      step();
      if (we_c === 1'b1) begin
        chk("rr_order", 32'(dat_c[23:16]), 32'(prev % 3));
        prev++;
      end
    end

    for (int k = 0; k < 300; k++) begin
      for (int d = 0; d < ND; d++) gen(d, 1);
      step();
    end
    for (int k = 0; k < 12; k++) begin
      for (int d = 0; d < ND; d++) gen(d, 0);
      step();
    end
    for (int c = 0; c < 3; c++) chk($sformatf("lost_ch%0d", c), 32'(outst[c]), 32'd0);
    chk("drain_busy_a", 32'(bsy_a), 32'd0);
    chk("drain_busy_c", 32'(bsy_c), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
